// File: rtl/fire_squeeze_layer.sv
// Fire-module squeeze conv engine: DSP_NO signed MAC lanes share one streamed ifm beat,
// then bias, ReLU and requantise each pixel. Define FIRE_SQUEEZE_SAT_EN to saturate instead of truncate.
module fire_squeeze_layer #(
   parameter int WIDTH      = 16,
   parameter int DSP_NO     = 112,
   parameter int CHIN       = 384,
   parameter int KERNEL_DIM = 1,
   parameter int WOUT       = 8,
   parameter int FRAC       = 14
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start_i,
   input  logic [WIDTH-1:0]                   ifm_i,
   input  logic                               ifm_valid_i,
   input  logic [DSP_NO-1:0][WIDTH-1:0]       kernels,
   input  logic [DSP_NO-1:0][2*WIDTH-1:0]     bias,
   input  logic                               ram_feedback_i,
   output logic                               rom_clr_pulse_o,
   output logic                               sample_o,
   output logic [DSP_NO-1:0][WIDTH-1:0]       ofm,
   output logic                               busy_o,
   output logic                               finish_o
);

   localparam int K      = KERNEL_DIM * KERNEL_DIM * CHIN;
   localparam int NPIX   = WOUT * WOUT;
   localparam int BEAT_W = (K > 1) ? $clog2(K) : 1;
   localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int PROD_W = 2 * WIDTH;
   localparam int ACC_W  = PROD_W + $clog2(K) + 1;
   localparam int SUM_W  = ACC_W + 1;

   localparam logic [BEAT_W-1:0]       BEAT_LAST = BEAT_W'(K - 1);
   localparam logic [PIX_W-1:0]        PIX_LAST  = PIX_W'(NPIX - 1);
   localparam logic signed [SUM_W-1:0] SUM_ZERO  = '0;
`ifdef FIRE_SQUEEZE_SAT_EN
   localparam logic signed [SUM_W-1:0] Q_MAX     = SUM_W'((2 ** (WIDTH - 1)) - 1);
`endif

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN,
      DONE
   } state_t;

   state_t state;
   state_t state_next;

   logic [BEAT_W-1:0]               beat_cnt;
   logic [PIX_W-1:0]                pix_cnt;
   logic                            accept;
   logic                            beat_wrap;
   logic                            pix_wrap;
   logic                            wrap_q;
   logic signed [PROD_W-1:0]        ifm_ext;
   logic [DSP_NO-1:0][WIDTH-1:0]    q_all;

   assign accept    = (state == ACCUM) && ifm_valid_i;
   assign beat_wrap = accept && (beat_cnt == BEAT_LAST);
   assign pix_wrap  = beat_wrap && (pix_cnt == PIX_LAST);
   assign ifm_ext   = PROD_W'($signed(ifm_i));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy_o     = 1'b0;
      finish_o   = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            busy_o = 1'b1;
            if (pix_wrap) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            busy_o     = 1'b1;
            state_next = DONE;
         end
         DONE: begin
            busy_o   = 1'b1;
            finish_o = 1'b1;
            if (ram_feedback_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // wrap_q marks that the accumulators hold a finished pixel; it doubles as the ROM rewind pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt <= '0;
         pix_cnt  <= '0;
         wrap_q   <= 1'b0;
      end else begin
         wrap_q <= beat_wrap;
         if (state == IDLE) begin
            beat_cnt <= '0;
            pix_cnt  <= '0;
         end else if (accept) begin
            if (beat_cnt == BEAT_LAST) begin
               beat_cnt <= '0;
               pix_cnt  <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

   assign rom_clr_pulse_o = wrap_q;

   for (genvar l = 0; l < DSP_NO; l++) begin : g_lane
      logic signed [PROD_W-1:0] ker_ext;
      logic signed [PROD_W-1:0] prod;
      logic signed [ACC_W-1:0]  prod_acc;
      logic signed [ACC_W-1:0]  acc;
      logic signed [SUM_W-1:0]  sum;
      logic [WIDTH-1:0]         q;
`ifdef FIRE_SQUEEZE_SAT_EN
      logic signed [SUM_W-1:0]  shifted;
`endif

      assign ker_ext  = PROD_W'($signed(kernels[l]));
      assign prod     = ifm_ext * ker_ext;
      assign prod_acc = ACC_W'(prod);
      assign sum      = SUM_W'(acc) + SUM_W'($signed(bias[l]));

      // beat 0 overwrites so the next pixel can start on the same edge the previous one is sampled
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            acc <= '0;
         end else if (accept) begin
            acc <= (beat_cnt == '0) ? prod_acc : acc + prod_acc;
         end
      end

`ifdef FIRE_SQUEEZE_SAT_EN
      assign shifted = sum >>> FRAC;

      always_comb begin
         q = '0;
         if (sum < SUM_ZERO) begin
            q = '0;
         end else if (shifted > Q_MAX) begin
            q = {1'b0, {(WIDTH - 1){1'b1}}};
         end else begin
            q = shifted[WIDTH-1:0];
         end
      end
`else
      // legacy behaviour: keep WIDTH-1 bits above the binary point, silently dropping overflow
      always_comb begin
         q = '0;
         if (sum < SUM_ZERO) begin
            q = '0;
         end else begin
            q = {1'b0, sum[FRAC+WIDTH-2:FRAC]};
         end
      end
`endif

      assign q_all[l] = q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ofm      <= '0;
         sample_o <= 1'b0;
      end else begin
         sample_o <= wrap_q;
         if (wrap_q) begin
            ofm <= q_all;
         end
      end
   end

endmodule

// File: tb/tb_fire_squeeze_layer.sv
// Self-checking bench for fire_squeeze_layer (K=4, two lanes, 2x2 output) against a per-pixel
// arithmetic reference; honours FIRE_SQUEEZE_SAT_EN when it is defined for the build.
module tb_fire_squeeze_layer;

   localparam int WIDTH      = 16;
   localparam int DSP_NO     = 2;
   localparam int CHIN       = 4;
   localparam int KERNEL_DIM = 1;
   localparam int WOUT       = 2;
   localparam int FRAC       = 14;
   localparam int K          = KERNEL_DIM * KERNEL_DIM * CHIN;
   localparam int NPIX       = WOUT * WOUT;

   logic                           clk = 1'b0;
   logic                           rst = 1'b0;
   logic                           start_i;
   logic [WIDTH-1:0]               ifm_i;
   logic                           ifm_valid_i;
   logic [DSP_NO-1:0][WIDTH-1:0]   kernels;
   logic [DSP_NO-1:0][2*WIDTH-1:0] bias;
   logic                           ram_feedback_i;
   logic                           rom_clr_pulse_o;
   logic                           sample_o;
   logic [DSP_NO-1:0][WIDTH-1:0]   ofm;
   logic                           busy_o;
   logic                           finish_o;

   int compared   = 0;
   int mismatched = 0;

   // reference model: running dot products per lane plus the layer-level progress the bench expects
   bit          m_busy;
   bit          m_active;
   int          m_beat;
   int          m_pix;
   int          m_samples;
   longint      m_sum[DSP_NO];
   bit          m_pend;
   logic [15:0] m_pend_q[DSP_NO];
   logic [15:0] m_ofm[DSP_NO];

   fire_squeeze_layer #(
      .WIDTH(WIDTH), .DSP_NO(DSP_NO), .CHIN(CHIN),
      .KERNEL_DIM(KERNEL_DIM), .WOUT(WOUT), .FRAC(FRAC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start_i(start_i),
      .ifm_i(ifm_i),
      .ifm_valid_i(ifm_valid_i),
      .kernels(kernels),
      .bias(bias),
      .ram_feedback_i(ram_feedback_i),
      .rom_clr_pulse_o(rom_clr_pulse_o),
      .sample_o(sample_o),
      .ofm(ofm),
      .busy_o(busy_o),
      .finish_o(finish_o)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] quant(input longint s);
      longint q;
      if (s < 0) return 16'h0000;
      q = s >>> FRAC;
`ifdef FIRE_SQUEEZE_SAT_EN
      if (q > 32767) return 16'h7FFF;
      return 16'(q);
`else
      return 16'(q & 64'h7FFF);
`endif
   endfunction

   function automatic logic [15:0] rnd16();
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(0, 1) == 1) r = {{3{r[15]}}, r[15:3]};
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic clearModel();
      m_busy    = 1'b0;
      m_active  = 1'b0;
      m_beat    = 0;
      m_pix     = 0;
      m_samples = 0;
      m_pend    = 1'b0;
      for (int l = 0; l < DSP_NO; l++) begin
         m_sum[l]    = 0;
         m_pend_q[l] = 16'h0;
         m_ofm[l]    = 16'h0;
      end
   endtask

   // one clock: drive inputs, let the edge pass, then compare every output with the model
   task automatic applyStimulus(input bit st, input bit fb, input bit v,
                                input logic [15:0] x, input logic [15:0] k0, input logic [15:0] k1);
      bit          fin_pre;
      bit          exp_sample;
      bit          exp_rom;
      logic [15:0] kk[DSP_NO];
      start_i        = st;
      ram_feedback_i = fb;
      ifm_valid_i    = v;
      ifm_i          = x;
      kernels[0]     = k0;
      kernels[1]     = k1;
      kk[0]          = k0;
      kk[1]          = k1;
      fin_pre        = m_busy && (m_samples == NPIX);
      @(posedge clk);
      @(negedge clk);
      exp_sample = m_pend;
      exp_rom    = 1'b0;
      if (m_pend) begin
         m_ofm = m_pend_q;
         m_samples++;
      end
      m_pend = 1'b0;
      if (m_active && v) begin
         for (int l = 0; l < DSP_NO; l++)
            m_sum[l] += longint'($signed(x)) * longint'($signed(kk[l]));
         m_beat++;
         if (m_beat == K) begin
            exp_rom = 1'b1;
            m_pend  = 1'b1;
            for (int l = 0; l < DSP_NO; l++) begin
               m_pend_q[l] = quant(m_sum[l] + longint'($signed(bias[l])));
               m_sum[l]    = 0;
            end
            m_beat = 0;
            m_pix++;
            if (m_pix == NPIX) m_active = 1'b0;
         end
      end
      if (!m_busy && st) begin
         m_busy    = 1'b1;
         m_active  = 1'b1;
         m_pix     = 0;
         m_samples = 0;
      end else if (fin_pre && fb) begin
         m_busy = 1'b0;
      end
      checkOutput("rom_clr", 32'(rom_clr_pulse_o), 32'(exp_rom));
      checkOutput("sample", 32'(sample_o), 32'(exp_sample));
      checkOutput("ofm0", 32'(ofm[0]), 32'(m_ofm[0]));
      checkOutput("ofm1", 32'(ofm[1]), 32'(m_ofm[1]));
      checkOutput("busy", 32'(busy_o), 32'(m_busy));
      checkOutput("finish", 32'(finish_o), 32'(m_busy && (m_samples == NPIX)));
   endtask

   task automatic doReset();
      rst = 1'b1;
      #1;
      checkOutput("rst_rom_clr", 32'(rom_clr_pulse_o), 32'd0);
      checkOutput("rst_sample", 32'(sample_o), 32'd0);
      checkOutput("rst_ofm", 32'(ofm), 32'd0);
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      checkOutput("rst_finish", 32'(finish_o), 32'd0);
      clearModel();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic directedPixel(input logic [15:0] x, input logic [15:0] k0, input logic [15:0] k1, input int gap);
      for (int b = 0; b < K; b++) begin
         repeat (gap) applyStimulus(1'b0, 1'b0, 1'b0, rnd16(), rnd16(), rnd16());
         applyStimulus(1'b0, 1'b0, 1'b1, x, k0, k1);
      end
   endtask

   // random pixel with random stalls; start/feedback noise is injected while the layer is running
   task automatic randomPixel(input int gapmax);
      for (int b = 0; b < K; b++) begin
         repeat ($urandom_range(0, gapmax))
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b0, rnd16(), rnd16(), rnd16());
         applyStimulus(1'b0, 1'b0, 1'b1, rnd16(), rnd16(), rnd16());
      end
   endtask

   task automatic finishLayer(input bit start_too);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, rnd16(), rnd16(), rnd16());
      checkOutput("finish_held", 32'(finish_o), 32'd1);
      applyStimulus(start_too, 1'b1, 1'b0, rnd16(), rnd16(), rnd16());
      checkOutput("idle_busy", 32'(busy_o), 32'd0);
   endtask

   initial begin
      start_i        = 1'b0;
      ifm_i          = '0;
      ifm_valid_i    = 1'b0;
      kernels        = '0;
      bias           = '0;
      ram_feedback_i = 1'b0;
      clearModel();
      doReset();
      repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, rnd16(), rnd16(), rnd16());

      // layer 1: basic product, then an overflowing pixel, then random pixels
      applyStimulus(1'b1, 1'b0, 1'b0, rnd16(), rnd16(), rnd16());
      directedPixel(16'h2000, 16'h2000, 16'hE000, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, rnd16(), rnd16(), rnd16());
      applyStimulus(1'b0, 1'b0, 1'b0, rnd16(), rnd16(), rnd16());
      checkOutput("t1_ofm0", 32'(ofm[0]), 32'h4000);
      checkOutput("t1_ofm1", 32'(ofm[1]), 32'h0000);
      directedPixel(16'h4000, 16'h4000, 16'h4000, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, rnd16(), rnd16(), rnd16());
      applyStimulus(1'b0, 1'b0, 1'b0, rnd16(), rnd16(), rnd16());
`ifdef FIRE_SQUEEZE_SAT_EN
      checkOutput("t2_ofm0", 32'(ofm[0]), 32'h7FFF);
`else
      checkOutput("t2_ofm0", 32'(ofm[0]), 32'h0000);
`endif
      randomPixel(2);
      randomPixel(2);
      finishLayer(1'b1);

      // layer 2: bias on lane 0, stalled beats, start/feedback pokes mid-layer
      bias[0] = 32'h0000_4000;
      bias[1] = 32'h0;
      applyStimulus(1'b1, 1'b0, 1'b0, rnd16(), rnd16(), rnd16());
      directedPixel(16'h2000, 16'h2000, 16'hE000, 3);
      applyStimulus(1'b1, 1'b1, 1'b0, rnd16(), rnd16(), rnd16());
      applyStimulus(1'b1, 1'b1, 1'b0, rnd16(), rnd16(), rnd16());
      checkOutput("t3_ofm0", 32'(ofm[0]), 32'h4001);
      checkOutput("t6_finish", 32'(finish_o), 32'd0);
      for (int p = 1; p < NPIX; p++) randomPixel(3);
      finishLayer(1'b0);

      // layer 3: every pixel back-to-back with valid held high
      bias = '0;
      applyStimulus(1'b1, 1'b0, 1'b0, rnd16(), rnd16(), rnd16());
      for (int b = 0; b < K * NPIX; b++) applyStimulus(1'b0, 1'b0, 1'b1, rnd16(), rnd16(), rnd16());
      finishLayer(1'b0);

      // layer 4: reset in the middle of pixel 1, then a complete layer
      applyStimulus(1'b1, 1'b0, 1'b0, rnd16(), rnd16(), rnd16());
      directedPixel(16'h2000, 16'h2000, 16'h2000, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h1000, 16'h1000, 16'h1000);
      applyStimulus(1'b0, 1'b0, 1'b1, 16'h1000, 16'h1000, 16'h1000);
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, rnd16(), rnd16(), rnd16());
      for (int p = 0; p < NPIX; p++) randomPixel(1);
      finishLayer(1'b0);

      // randomised layers with random bias
      for (int n = 0; n < 6; n++) begin
         for (int l = 0; l < DSP_NO; l++) begin
            bias[l] = 32'($urandom);
            if ($urandom_range(0, 1) == 1) bias[l] = {{8{bias[l][31]}}, bias[l][31:8]};
         end
         applyStimulus(1'b1, 1'b0, 1'b0, rnd16(), rnd16(), rnd16());
         for (int p = 0; p < NPIX; p++) randomPixel($urandom_range(0, 3));
         finishLayer($urandom_range(0, 1) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
